if_network_seq: RTL and testbench

- Time-multiplexed integrate-and-fire network: one shared accumulate/compare datapath evaluates every neuron of every layer in sequence, once per timestep.
- Weights, membrane potentials and refractory counters live in internal memories.
- All layers are evaluated within one timestep. Layer l+1 sees layer l spikes from the same step, so there is no per-layer pipeline delay.
- Host weight access uses the same layer-select addressing scheme as the existing network blocks.

---
 rtl/if_network_seq_if.sv | 28 ++
 rtl/if_network_seq.sv | 207 ++++++++++++++++++++
 tb/tb_if_network_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_network_seq_if.sv
// Host-side bundle for the time-multiplexed integrate-and-fire network:
// step handshake, spike vectors and the weight memory port.
interface if_network_seq_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int MAX_NEURONS = 8,
    parameter int WEIGHT_SIZE = 32
);
    logic                   step_start;
    logic [NUM_INPUTS-1:0]  spike_in;
    logic                   step_busy;
    logic                   step_done;
    logic [MAX_NEURONS-1:0] spike_out;
    logic                   state_clr;
    logic [31:0]            mem_addr;
    logic [WEIGHT_SIZE-1:0] mem_din;
    logic                   mem_wen;
    logic [WEIGHT_SIZE-1:0] mem_dout;

    modport master (
        output step_start, spike_in, state_clr, mem_addr, mem_din, mem_wen,
        input  step_busy, step_done, spike_out, mem_dout
    );

    modport slave (
        input  step_start, spike_in, state_clr, mem_addr, mem_din, mem_wen,
        output step_busy, step_done, spike_out, mem_dout
    );
endinterface

// File: rtl/if_network_seq.sv
// Integrate-and-fire network evaluated neuron by neuron through one shared
// accumulate/compare datapath; all layers are swept within a single timestep.
module if_network_seq #(
    parameter int THRESH      = 15,
    parameter int RESET       = 0,
    parameter int REFRAC      = 5,
    parameter int WEIGHT_SIZE = 32,
    parameter int NUM_INPUTS  = 4,
    parameter int MAX_NEURONS = 8,
    parameter int NUM_LAYERS  = 2,
    parameter int LEAK_EN     = 0,
    parameter int LEAK        = 1,
    parameter int FANIN_MAX   = (NUM_INPUTS > MAX_NEURONS) ? NUM_INPUTS : MAX_NEURONS
) (
    input  logic           clk,
    input  logic           rst,
    if_network_seq_if.slave bus
);
    localparam int LAYER_WORDS = MAX_NEURONS * FANIN_MAX;
    localparam int DEPTH       = NUM_LAYERS * LAYER_WORDS;
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FIW         = (FANIN_MAX > 1) ? $clog2(FANIN_MAX) : 1;
    localparam int NIW         = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;
    localparam int NPOT        = NUM_LAYERS * MAX_NEURONS;
    localparam int PIW         = (NPOT > 1) ? $clog2(NPOT) : 1;
    localparam int FV          = 2 ** FIW;
    localparam int NV          = 2 ** NIW;
    localparam int RW          = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int ACC_W       = WEIGHT_SIZE + $clog2(FANIN_MAX);
    localparam int SUM_W       = ACC_W + 2;

    localparam logic signed [WEIGHT_SIZE-1:0] THRESH_W = WEIGHT_SIZE'(THRESH);
    localparam logic signed [WEIGHT_SIZE-1:0] RESET_W  = WEIGHT_SIZE'(RESET);
    localparam logic [RW-1:0]                 REFRAC_W = RW'(REFRAC);
    localparam logic [SUM_W-1:0]              LEAK_SUB = (LEAK_EN != 0) ? SUM_W'(LEAK) : '0;
    localparam logic [3:0]                    LAYER_LAST  = 4'(NUM_LAYERS - 1);
    localparam logic [NIW-1:0]                NEURON_LAST = NIW'(MAX_NEURONS - 1);
    localparam logic signed [WEIGHT_SIZE-1:0] MAX_V = {1'b0, {(WEIGHT_SIZE-1){1'b1}}};
    localparam logic signed [WEIGHT_SIZE-1:0] MIN_V = {1'b1, {(WEIGHT_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_UPDATE, S_DONE} state_t;

    state_t                          state_reg, state_next;
    logic [3:0]                      layer_reg;
    logic [NIW-1:0]                  neuron_reg;
    logic [FIW-1:0]                  in_reg;
    logic                            vld_d_reg, bit_d_reg;
    logic signed [ACC_W-1:0]         acc_reg;
    logic [FV-1:0]                   in_vec_reg;
    logic [NV-1:0]                   cur_spk_reg, cur_spk_next;
    logic [MAX_NEURONS-1:0]          spike_out_reg;
    logic [WEIGHT_SIZE-1:0]          mem_dout_reg;
    logic signed [WEIGHT_SIZE-1:0]   w_reg;
    logic [WEIGHT_SIZE-1:0]          wmem [DEPTH];

    logic [FIW-1:0]                  fanin_last;
    logic [31:0]                     fetch_lin, host_lin, upd_lin;
    logic [AW-1:0]                   fetch_idx, host_idx;
    logic [PIW-1:0]                  upd_idx;
    logic                            host_ok;
    logic [NPOT*WEIGHT_SIZE-1:0]     pot_flat;
    logic [NPOT*RW-1:0]              ref_flat;
    logic signed [WEIGHT_SIZE-1:0]   pot_cur, pot_new, sat_v;
    logic [RW-1:0]                   ref_cur, ref_new;
    logic signed [SUM_W-1:0]         sum_v;
    logic [SUM_W-WEIGHT_SIZE:0]      sum_top;
    logic                            spk_new;

    assign fanin_last = (layer_reg == 4'd0) ? FIW'(NUM_INPUTS - 1) : FIW'(MAX_NEURONS - 1);
    assign fetch_lin  = 32'(layer_reg) * 32'(LAYER_WORDS) + 32'(neuron_reg) * 32'(FANIN_MAX)
                      + 32'(in_reg);
    assign fetch_idx  = fetch_lin[AW-1:0];
    assign host_lin   = 32'(bus.mem_addr[31:28]) * 32'(LAYER_WORDS) + {4'b0, bus.mem_addr[27:0]};
    assign host_idx   = host_lin[AW-1:0];
    assign host_ok    = (32'(bus.mem_addr[31:28]) < NUM_LAYERS)
                      && ({4'b0, bus.mem_addr[27:0]} < 32'(LAYER_WORDS));
    assign upd_lin    = 32'(layer_reg) * 32'(MAX_NEURONS) + 32'(neuron_reg);
    assign upd_idx    = upd_lin[PIW-1:0];

    // Weight array: host port writes/reads in IDLE, datapath reads during FETCH.
    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE && bus.mem_wen && host_ok)
            wmem[host_idx] <= bus.mem_din;
        w_reg <= wmem[fetch_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            mem_dout_reg <= '0;
        else if (state_reg == S_IDLE)
            mem_dout_reg <= host_ok ? wmem[host_idx] : '0;
    end

    // Per-neuron membrane and refractory state, clearable in one cycle.
    for (genvar gi = 0; gi < NPOT; gi++) begin : g_cell
        logic signed [WEIGHT_SIZE-1:0] pot_reg;
        logic [RW-1:0]                 ref_reg;
        always_ff @(posedge clk) begin
            if (!rst || (state_reg == S_IDLE && bus.state_clr)) begin
                pot_reg <= '0;
                ref_reg <= '0;
            end else if (state_reg == S_UPDATE && upd_idx == PIW'(gi)) begin
                pot_reg <= pot_new;
                ref_reg <= ref_new;
            end
        end
        assign pot_flat[gi*WEIGHT_SIZE +: WEIGHT_SIZE] = pot_reg;
        assign ref_flat[gi*RW +: RW]                   = ref_reg;
    end

    always_comb begin
        pot_cur = pot_flat[upd_idx*WEIGHT_SIZE +: WEIGHT_SIZE];
        ref_cur = ref_flat[upd_idx*RW +: RW];
        sum_v   = SUM_W'(pot_cur) + SUM_W'(acc_reg) - LEAK_SUB;
        sum_top = sum_v[SUM_W-1:WEIGHT_SIZE-1];
        // The wide sum only needs clamping when its upper bits disagree with the sign.
        if ((&sum_top) || !(|sum_top))
            sat_v = sum_v[WEIGHT_SIZE-1:0];
        else
            sat_v = sum_v[SUM_W-1] ? MIN_V : MAX_V;
        spk_new = 1'b0;
        pot_new = pot_cur;
        ref_new = '0;
        if (ref_cur != '0) begin
            ref_new = ref_cur - RW'(1);
        end else if (sat_v >= THRESH_W) begin
            spk_new = 1'b1;
            pot_new = RESET_W;
            ref_new = REFRAC_W;
        end else begin
            pot_new = sat_v;
        end
        cur_spk_next             = cur_spk_reg;
        cur_spk_next[neuron_reg] = spk_new;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.step_start) state_next = S_FETCH;
            S_FETCH:  if (in_reg == fanin_last) state_next = S_DRAIN;
            S_DRAIN:  state_next = S_UPDATE;
            S_UPDATE: if (neuron_reg == NEURON_LAST && layer_reg == LAYER_LAST)
                          state_next = S_DONE;
                      else
                          state_next = S_FETCH;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            layer_reg     <= '0;
            neuron_reg    <= '0;
            in_reg        <= '0;
            vld_d_reg     <= 1'b0;
            bit_d_reg     <= 1'b0;
            acc_reg       <= '0;
            in_vec_reg    <= '0;
            cur_spk_reg   <= '0;
            spike_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            vld_d_reg <= (state_reg == S_FETCH);
            bit_d_reg <= in_vec_reg[in_reg];
            case (state_reg)
                S_IDLE: if (bus.step_start) begin
                    layer_reg  <= '0;
                    neuron_reg <= '0;
                    in_reg     <= '0;
                    in_vec_reg <= FV'(bus.spike_in);
                end
                S_FETCH: begin
                    in_reg <= (in_reg == fanin_last) ? '0 : in_reg + FIW'(1);
                    // Weights arrive one cycle after their address; index 0 starts a fresh sum.
                    if (in_reg == '0)
                        acc_reg <= '0;
                    else if (vld_d_reg && bit_d_reg)
                        acc_reg <= acc_reg + ACC_W'(w_reg);
                end
                S_DRAIN: if (vld_d_reg && bit_d_reg) acc_reg <= acc_reg + ACC_W'(w_reg);
                S_UPDATE: begin
                    cur_spk_reg <= cur_spk_next;
                    if (neuron_reg == NEURON_LAST) begin
                        neuron_reg <= '0;
                        if (layer_reg == LAYER_LAST) begin
                            spike_out_reg <= cur_spk_next[MAX_NEURONS-1:0];
                        end else begin
                            layer_reg  <= layer_reg + 4'd1;
                            in_vec_reg <= FV'(cur_spk_next);
                        end
                    end else begin
                        neuron_reg <= neuron_reg + NIW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.step_busy = (state_reg != S_IDLE);
    assign bus.step_done = (state_reg == S_DONE);
    assign bus.spike_out = spike_out_reg;
    assign bus.mem_dout  = mem_dout_reg;
endmodule

// File: tb/tb_if_network_seq.sv
// Directed bench for if_network_seq: three instances (plain, leaky, high
// threshold) share one stimulus stream; each phase checks the relevant one.
module tb_if_network_seq;
    localparam int NI = 4, NN = 2, NL = 2, W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          step_start = 1'b0;
    logic [NI-1:0] spike_in = '0;
    logic          state_clr = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [W-1:0]  mem_din = '0;
    logic          mem_wen = 1'b0;

    int checks = 0;
    int errors = 0;

    if_network_seq_if #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .WEIGHT_SIZE(W)) ia ();
    if_network_seq_if #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .WEIGHT_SIZE(W)) il ();
    if_network_seq_if #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .WEIGHT_SIZE(W)) is ();

    assign ia.step_start = step_start; assign ia.spike_in = spike_in; assign ia.state_clr = state_clr;
    assign ia.mem_addr = mem_addr; assign ia.mem_din = mem_din; assign ia.mem_wen = mem_wen;
    assign il.step_start = step_start; assign il.spike_in = spike_in; assign il.state_clr = state_clr;
    assign il.mem_addr = mem_addr; assign il.mem_din = mem_din; assign il.mem_wen = mem_wen;
    assign is.step_start = step_start; assign is.spike_in = spike_in; assign is.state_clr = state_clr;
    assign is.mem_addr = mem_addr; assign is.mem_din = mem_din; assign is.mem_wen = mem_wen;

    if_network_seq #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .NUM_LAYERS(NL), .WEIGHT_SIZE(W))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    if_network_seq #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .NUM_LAYERS(NL), .WEIGHT_SIZE(W),
                     .LEAK_EN(1), .LEAK(1))
        dut_l (.clk(clk), .rst(rst), .bus(il));
    if_network_seq #(.NUM_INPUTS(NI), .MAX_NEURONS(NN), .NUM_LAYERS(NL), .WEIGHT_SIZE(W),
                     .THRESH(32'h7FFF_FFFF))
        dut_s (.clk(clk), .rst(rst), .bus(is));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [W-1:0] d);
        mem_addr = a; mem_din = d; mem_wen = 1'b1;
        tick();
        mem_wen = 1'b0;
        $display("write addr=%08h data=%08h", a, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [W-1:0] d);
        mem_addr = a;
        tick();
        d = ia.mem_dout;
        $display("read  addr=%08h data=%08h", a, d);
    endtask

    task automatic zero_all();
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < NN * NI; k++)
                wr((32'(l) << 28) | 32'(k), '0);
    endtask

    task automatic prog_prop();
        zero_all();
        for (int i = 0; i < NI; i++) wr(32'(i), 32'd4);
        wr(32'h1000_0000, 32'd15);
    endtask

    // Bounded wait for step_done; cyc is the cycle number counted from acceptance (0 if timed out).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (ia.step_done === 1'b1) begin
                cyc = k + 1;
                break;
            end
        end
        tick();
    endtask

    task automatic run_step(input logic [NI-1:0] si, input logic clr, input string tag);
        int cyc;
        spike_in = si; step_start = 1'b1; state_clr = clr;
        tick();
        step_start = 1'b0; state_clr = 1'b0;
        wait_done(cyc);
        check({tag, "_cycles"}, 64'(cyc), 64'd21);
        $display("step %s in=%b done_cycle=%0d a=%b l=%b s=%b", tag, si, cyc,
                 ia.spike_out, il.spike_out, is.spike_out);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [W-1:0] d;
    int           cnt, cyc;
    logic [NN-1:0] exp_ref [7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    initial begin
        // Reset values
        tick(); tick();
        check("rst_spike_out", 64'(ia.spike_out), 64'd0);
        check("rst_busy",      64'(ia.step_busy), 64'd0);
        check("rst_done",      64'(ia.step_done), 64'd0);
        check("rst_mem_dout",  64'(ia.mem_dout),  64'd0);
        rst = 1'b1;

        // All-zero weights: no spikes, done at cycle 21, busy during, single-cycle done
        zero_all();
        spike_in = 4'b1111; step_start = 1'b1;
        tick();
        step_start = 1'b0;
        check("busy_after_accept", 64'(ia.step_busy), 64'd1);
        wait_done(cyc);
        check("zero_cycles", 64'(cyc), 64'd21);
        check("zero_spike_out", 64'(ia.spike_out), 64'd0);
        check("done_pulse_width", 64'(ia.step_done), 64'd0);
        check("idle_after_done", 64'(ia.step_busy), 64'd0);

        // Weight port
        wr(32'h1000_0003, 32'd5);
        rd(32'h1000_0003, d);
        check("rd_back", 64'(d), 64'd5);
        wr(32'hF000_0003, 32'd9);
        rd(32'hF000_0003, d);
        check("rd_bad_layer", 64'(d), 64'd0);
        mem_addr = 32'h1000_0003; mem_din = 32'd7; mem_wen = 1'b1;
        tick();
        mem_wen = 1'b0;
        check("rdw_old", 64'(ia.mem_dout), 64'd5);
        rd(32'h1000_0003, d);
        check("rdw_new", 64'(d), 64'd7);

        // Same-step propagation followed by refractory pattern
        prog_prop();
        for (int s = 0; s < 7; s++) begin
            run_step(4'b1111, 1'b0, $sformatf("refrac%0d", s));
            check($sformatf("refrac_spike%0d", s), 64'(ia.spike_out), 64'(exp_ref[s]));
        end

        // state_clr alone, then together with step_start
        state_clr = 1'b1;
        tick();
        state_clr = 1'b0;
        run_step(4'b1111, 1'b0, "clr");
        check("clr_spike", 64'(ia.spike_out), 64'd1);
        run_step(4'b1111, 1'b1, "clr_start");
        check("clr_start_spike", 64'(ia.spike_out), 64'd1);

        // step_start and mem_wen while busy are ignored
        spike_in = 4'b1111; step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick(); tick();
        step_start = 1'b1; mem_addr = 32'h0; mem_din = 32'd0; mem_wen = 1'b1;
        tick();
        step_start = 1'b0; mem_wen = 1'b0;
        wait_done(cyc);
        check("busy_step_finished", 64'(cyc != 0), 64'd1);
        check("busy_step_spike", 64'(ia.spike_out), 64'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ia.step_busy === 1'b1) cnt++;
        end
        check("no_second_step", 64'(cnt), 64'd0);
        rd(32'h0, d);
        check("busy_write_dropped", 64'(d), 64'd4);

        // Reset in the middle of FETCH
        spike_in = 4'b1111; step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", 64'(ia.step_busy), 64'd0);
        check("midrst_done", 64'(ia.step_done), 64'd0);
        check("midrst_spike", 64'(ia.spike_out), 64'd0);
        check("midrst_dout", 64'(ia.mem_dout), 64'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ia.step_done === 1'b1 || ia.step_busy === 1'b1) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'd0);
        prog_prop();
        run_step(4'b1111, 1'b0, "fresh");
        check("fresh_spike", 64'(ia.spike_out), 64'd1);

        // Leak: +3 -1 per step reaches 16 on step 8
        do_reset();
        zero_all();
        wr(32'h0, 32'd3);
        wr(32'h1000_0000, 32'd100);
        for (int s = 1; s <= 8; s++) begin
            run_step(4'b0001, 1'b0, $sformatf("leak%0d", s));
            check($sformatf("leak_spike%0d", s), 64'(il.spike_out), (s == 8) ? 64'd1 : 64'd0);
        end

        // Saturation: four max weights clamp to max instead of wrapping negative
        do_reset();
        zero_all();
        for (int i = 0; i < NI; i++) wr(32'(i), 32'h7FFF_FFFF);
        for (int i = 0; i < NI; i++) wr(32'(NI + i), 32'h8000_0000);
        wr(32'h1000_0000, 32'h7FFF_FFFF);
        run_step(4'b1111, 1'b0, "sat1");
        check("sat_spike", 64'(is.spike_out), 64'd1);
        run_step(4'b1111, 1'b0, "sat2");
        check("sat_refrac", 64'(is.spike_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
